reg_file_mp_sb: RTL and testbench

//  Parametrised multi-read-port register file for the ARM pipeline ID stage, with write-through

---
 rtl/reg_file_mp_sb.sv | 141 ++++++++++++++
 tb/tb_reg_file_mp_sb.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/reg_file_mp_sb.sv
`timescale 1ns/1ps
// reg_file_mp_sb: multi-read-port register file for the ID stage.
// Provides write-through bypass on reads, a per-register pending-write
// scoreboard for the hazard unit, and a one-register-per-cycle clear engine.
module reg_file_mp_sb #(
    parameter int WORD_WIDTH = 32,
    parameter int ADDR_W     = 4,
    parameter int NUM_REGS   = 16,
    parameter int NUM_RD     = 3,
    parameter int INIT_MODE  = 1
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_clear_req,
    input  logic [NUM_RD*ADDR_W-1:0]     i_rd_addr,
    output logic [NUM_RD*WORD_WIDTH-1:0] o_rd_data,
    input  logic                         i_wb_en,
    input  logic [ADDR_W-1:0]            i_wb_dest,
    input  logic [WORD_WIDTH-1:0]        i_wb_result,
    input  logic                         i_issue_en,
    input  logic [ADDR_W-1:0]            i_issue_dest,
    output logic [NUM_REGS-1:0]          o_pend_mask,
    output logic                         o_ready
);

    typedef enum logic {S_IDLE = 1'b0, S_CLEAR = 1'b1} state_t;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);
    localparam logic [ADDR_W:0]   NREGS    = (ADDR_W + 1)'(NUM_REGS);

    state_t                  r_state, w_state_nxt;
    logic [ADDR_W-1:0]       r_cnt, w_cnt_nxt;
    logic [WORD_WIDTH-1:0]   r_regs [NUM_REGS];
    logic [NUM_REGS-1:0]     r_pend;
    logic                    w_ready;
    logic                    w_clear_start;
    logic                    w_wr_ok;

    // Contents a register takes on reset or clear.
    function automatic logic [WORD_WIDTH-1:0] init_val(input int idx);
        logic [WORD_WIDTH-1:0] v;
        if (INIT_MODE == 1) v = WORD_WIDTH'(idx);
        else                v = '0;
        return v;
    endfunction

    assign w_ready       = (r_state == S_IDLE);
    assign w_clear_start = w_ready && i_clear_req;
    // A write-back is only honoured when idle and addressed to a real register;
    // the same qualifier gates the read bypass so the two never disagree.
    assign w_wr_ok       = i_wb_en && w_ready && ({1'b0, i_wb_dest} < NREGS);

    // Clear engine state and counter registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Clear engine next-state: walk cnt 0..NUM_REGS-1, then return to idle.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (i_clear_req) begin
                    w_state_nxt = S_CLEAR;
                    w_cnt_nxt   = '0;
                end
            end
            S_CLEAR: begin
                if (r_cnt == LAST_IDX) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Register storage: clear engine owns the array while running, else write-back.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= init_val(i);
        end else if (r_state == S_CLEAR) begin
            for (int i = 0; i < NUM_REGS; i++)
                if (r_cnt == ADDR_W'(i)) r_regs[i] <= init_val(i);
        end else begin
            for (int i = 0; i < NUM_REGS; i++)
                if (w_wr_ok && (i_wb_dest == ADDR_W'(i))) r_regs[i] <= i_wb_result;
        end
    end

    // Pending-write scoreboard: issue sets (and beats a same-cycle write-back), write-back clears.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_pend <= '0;
        end else if (w_clear_start || !w_ready) begin
            r_pend <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (i_issue_en && (i_issue_dest == ADDR_W'(i)))
                    r_pend[i] <= 1'b1;
                else if (i_wb_en && (i_wb_dest == ADDR_W'(i)))
                    r_pend[i] <= 1'b0;
            end
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0]     w_addr;
        logic [WORD_WIDTH-1:0] w_val;
        logic                  w_byp;

        assign w_addr = i_rd_addr[k*ADDR_W +: ADDR_W];
        assign w_byp  = w_wr_ok && (i_wb_dest == w_addr);

        // Read mux: unmatched (out-of-range) addresses fall through to zero.
        always_comb begin
            w_val = '0;
            for (int i = 0; i < NUM_REGS; i++)
                if (w_addr == ADDR_W'(i)) w_val = r_regs[i];
            if (w_byp) w_val = i_wb_result;
        end

        assign o_rd_data[k*WORD_WIDTH +: WORD_WIDTH] = w_val;
    end

    assign o_pend_mask = r_pend;
    assign o_ready     = w_ready;

endmodule

// File: tb/tb_reg_file_mp_sb.sv
`timescale 1ns/1ps
// Directed bench for reg_file_mp_sb: expected values are queued as stimulus
// is applied and popped when the corresponding output is sampled.
module tb_reg_file_mp_sb;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, clear_req, wb_en, issue_en;
    logic [11:0] rd_addr;
    logic [3:0]  wb_dest, issue_dest;
    logic [31:0] wb_result;
    logic [95:0] rd_data, rd_data12;
    logic [15:0] pend;
    logic [11:0] pend12;
    logic        ready, ready12;

    int n_pass  = 0;
    int n_total = 0;
    int n;

    string       q_tag[$];
    logic [31:0] q_exp[$];

    reg_file_mp_sb dut (
        .i_clk(clk), .i_rst(rst), .i_clear_req(clear_req), .i_rd_addr(rd_addr),
        .o_rd_data(rd_data), .i_wb_en(wb_en), .i_wb_dest(wb_dest),
        .i_wb_result(wb_result), .i_issue_en(issue_en), .i_issue_dest(issue_dest),
        .o_pend_mask(pend), .o_ready(ready)
    );

    reg_file_mp_sb #(.NUM_REGS(12)) dut12 (
        .i_clk(clk), .i_rst(rst), .i_clear_req(clear_req), .i_rd_addr(rd_addr),
        .o_rd_data(rd_data12), .i_wb_en(wb_en), .i_wb_dest(wb_dest),
        .i_wb_result(wb_result), .i_issue_en(issue_en), .i_issue_dest(issue_dest),
        .o_pend_mask(pend12), .o_ready(ready12)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic expect_val(input string tag, input logic [31:0] e);
        q_tag.push_back(tag);
        q_exp.push_back(e);
    endtask

    task automatic check(input logic [31:0] obs);
        string       tag;
        logic [31:0] e;
        n_total++;
        if (q_exp.size() == 0) begin
            $error("FAIL sb_underflow: observed %h, no expected value queued", obs);
        end else begin
            tag = q_tag.pop_front();
            e   = q_exp.pop_front();
            assert (obs === e) n_pass++;
            else $error("FAIL %s: observed %h expected %h", tag, obs, e);
        end
    endtask

    function automatic logic [31:0] port(input logic [95:0] d, input int k);
        return d[k*32 +: 32];
    endfunction

    task automatic set_addr(input int k, input logic [3:0] a);
        rd_addr[k*4 +: 4] = a;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; clear_req = 1'b0; wb_en = 1'b0; issue_en = 1'b0;
        wb_dest = '0; issue_dest = '0; wb_result = '0; rd_addr = '0;

        // 1: reset contents, empty scoreboard, ready
        set_addr(0, 4'd0); set_addr(1, 4'd1); set_addr(2, 4'd2);
        tick();
        expect_val("rst_rd0", 32'd0); expect_val("rst_rd1", 32'd1); expect_val("rst_rd2", 32'd2);
        expect_val("rst_pend", 32'd0); expect_val("rst_ready", 32'd1);
        check(port(rd_data, 0)); check(port(rd_data, 1)); check(port(rd_data, 2));
        check({16'b0, pend}); check({31'b0, ready});
        rst = 1'b0;
        tick();

        // 2: write-through bypass then stored value
        wb_en = 1'b1; wb_dest = 4'd5; wb_result = 32'hDEADBEEF; set_addr(0, 4'd5);
        expect_val("bypass_r5", 32'hDEADBEEF);
        settle(); check(port(rd_data, 0));
        tick(); wb_en = 1'b0;
        expect_val("stored_r5", 32'hDEADBEEF);
        settle(); check(port(rd_data, 0));

        // 3: scoreboard set / clear / same-cycle issue wins
        issue_en = 1'b1; issue_dest = 4'd3;
        tick(); issue_en = 1'b0;
        expect_val("pend_set3", 32'h8);
        settle(); check({16'b0, pend});
        wb_en = 1'b1; wb_dest = 4'd3; wb_result = 32'h33;
        tick(); wb_en = 1'b0;
        expect_val("pend_clr3", 32'h0);
        settle(); check({16'b0, pend});
        issue_en = 1'b1; issue_dest = 4'd3; wb_en = 1'b1; wb_dest = 4'd3; wb_result = 32'h3333;
        tick(); issue_en = 1'b0; wb_en = 1'b0; set_addr(1, 4'd3);
        expect_val("pend_issue_wins", 32'h8); expect_val("r3_written", 32'h3333);
        settle(); check({16'b0, pend}); check(port(rd_data, 1));

        // 4: clear engine
        wb_en = 1'b1; wb_dest = 4'd7; wb_result = 32'h55;
        tick(); wb_en = 1'b0; set_addr(0, 4'd7);
        expect_val("r7_55", 32'h55);
        settle(); check(port(rd_data, 0));
        issue_en = 1'b1; issue_dest = 4'd9; clear_req = 1'b1;
        expect_val("ready_at_req", 32'd1);
        settle(); check({31'b0, ready});
        tick(); clear_req = 1'b0;
        issue_en = 1'b1; issue_dest = 4'd10; wb_en = 1'b1; wb_dest = 4'd7; wb_result = 32'hAA;
        expect_val("pend_forced0", 32'h0); expect_val("no_bypass_clr", 32'h55);
        expect_val("ready_low", 32'd0);
        settle(); check({16'b0, pend}); check(port(rd_data, 0)); check({31'b0, ready});
        n = 0;
        while (ready !== 1'b1 && n < 40) begin
            n++;
            tick(); settle();
        end
        wb_en = 1'b0; issue_en = 1'b0; set_addr(1, 4'd5);
        expect_val("clear_len", 32'd16);
        check(n);
        expect_val("r7_cleared", 32'd7); expect_val("r5_cleared", 32'd5);
        expect_val("pend_after_clr", 32'h0);
        settle(); check(port(rd_data, 0)); check(port(rd_data, 1)); check({16'b0, pend});

        // 5: reset aborts a clear at cycle 6
        wb_en = 1'b1; wb_dest = 4'd12; wb_result = 32'hCC;
        tick(); wb_en = 1'b0; clear_req = 1'b1;
        tick(); clear_req = 1'b0;
        repeat (6) tick();
        expect_val("ready_mid_clr", 32'd0);
        settle(); check({31'b0, ready});
        rst = 1'b1;
        expect_val("ready_rst_abort", 32'd1);
        settle(); check({31'b0, ready});
        for (int i = 0; i < 16; i++) begin
            set_addr(0, 4'(i));
            expect_val($sformatf("rst_reg%0d", i), 32'(i));
            settle(); check(port(rd_data, 0));
        end
        tick(); rst = 1'b0;
        tick(); clear_req = 1'b1;
        tick(); clear_req = 1'b0;
        n = 0;
        while (ready !== 1'b1 && n < 40) begin
            n++;
            tick(); settle();
        end
        expect_val("clear_len_after_rst", 32'd16);
        check(n);

        // 6: NUM_REGS=12 instance, out-of-range accesses
        rst = 1'b1;
        tick(); rst = 1'b0;
        wb_en = 1'b1; wb_dest = 4'd15; wb_result = 32'h1234;
        issue_en = 1'b1; issue_dest = 4'd15;
        set_addr(0, 4'd14); set_addr(1, 4'd15); set_addr(2, 4'd11);
        expect_val("oor_rd14", 32'h0); expect_val("oor_no_byp15", 32'h0);
        expect_val("r11_init", 32'd11); expect_val("ready12", 32'd1);
        settle(); check(port(rd_data12, 0)); check(port(rd_data12, 1));
        check(port(rd_data12, 2)); check({31'b0, ready12});
        tick(); wb_en = 1'b0; issue_en = 1'b0;
        expect_val("oor_pend12", 32'h0); expect_val("oor_rd14_after", 32'h0);
        expect_val("r11_untouched", 32'd11);
        settle(); check({20'b0, pend12}); check(port(rd_data12, 0)); check(port(rd_data12, 2));
        wb_en = 1'b1; wb_dest = 4'd11; wb_result = 32'hBB;
        issue_en = 1'b1; issue_dest = 4'd11;
        expect_val("r11_bypass", 32'hBB);
        settle(); check(port(rd_data12, 2));
        tick(); wb_en = 1'b0; issue_en = 1'b0;
        expect_val("r11_stored", 32'hBB); expect_val("pend12_bit11", 32'h800);
        settle(); check(port(rd_data12, 2)); check({20'b0, pend12});

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
